i2c_slave_addr_matcher: RTL and testbench
=========================================

// Module: i2c_slave_addr_matcher
// PURPOSE
// I2C slave front end: glitch-filters SDA/SCL, flags START/repeated-START/STOP, and decodes the address phase against NUM_ADDR programmable slots.
// Each slot is 7-bit or 10-bit, with 10-bit repeated-START read support and optional general call.
// Sits between the SDA/SCL input synchronisers and the slave controller FSM, which owns the rx shift register and ACK drive.
// PARAMETERS
// NUM_ADDR    2  number of address slots (>=1); IDX_W = max(1,$clog2(NUM_ADDR))
// FILTER_LEN  3  consecutive agreeing samples required before a filtered line changes (>=1)
// GCALL_EN    1  1 = respond to general call address 0x00 with a write
// PORTS
// clk           in   1             system clock
// n_rst         in   1             asynchronous active-low reset
// SDA_sync      in   1             SDA from the pad synchroniser
// SCL_sync      in   1             SCL from the pad synchroniser
// rx_data       in   8             last received byte
// byte_valid    in   1             1-cycle pulse: rx_data holds a complete byte
// bus_address   in   10*NUM_ADDR   slot i at [10i+9:10i]; 7-bit slots use [6:0]
// address_mode  in   NUM_ADDR      per slot: 0 = 7-bit, 1 = 10-bit
// addr_enable   in   NUM_ADDR      per-slot enable
// start         out  1             START pulse (includes repeated START)
// rstart        out  1             repeated-START pulse (START while bus_busy)
// stop          out  1             STOP pulse
// bus_busy      out  1             high from START to STOP
// rw_mode       out  1             R/W bit of the last first address byte (1 = read)
// addr_done     out  1             1-cycle pulse: address phase resolved
// match_hit     out  1             addressed (slot hit or general call)
// match_idx     out  IDX_W         winning slot index
// gcall         out  1             general call hit
// BEHAVIOUR
// - Clock and reset: one clock, clk. n_rst is asynchronous and active-low.
// - Reset: every output is 0. FSM is IDLE. Sync FFs, filter shift registers and filtered lines reset to 1 (idle bus), so no false START follows reset. Reset mid-transfer aborts with no pulses.
// - Filter: each line passes through 2 sync FFs, then a FILTER_LEN shift register. The filtered line takes the new value one edge after all FILTER_LEN stages agree.
// - START = filtered SCL high on the current and previous cycle AND filtered SDA 1->0.
// - STOP = the same SCL condition AND filtered SDA 0->1.
// - Pulses are registered and exactly one cycle wide.
// - Latency: SDA_sync first sampled at edge 0 -> start/stop high in the cycle after edge FILTER_LEN+3.
// - START and STOP are mutually exclusive. rstart fires in the same cycle as start when bus_busy=1.
// - FSM states: IDLE, ADDR1, ADDR2, ACTIVE, IGNORE.
// - Any state: start -> ADDR1; stop -> IDLE. Both clear match_hit and gcall. A byte_valid coincident with start/stop is discarded.
// - ADDR1 on byte_valid: rw_mode <= rx_data[0]. Outcomes in priority order:
//   a) GCALL_EN and rx_data==0x00 -> gcall=1, match_hit=1, match_idx=0, addr_done, go to ACTIVE.
//   b) Any enabled 7-bit slot with rx_data[7:1]==addr[6:0] -> hit; the lowest index wins; go to ACTIVE.
//   c) rx_data[7:3]==5'b11110 with rw=0 and some enabled 10-bit slot has addr[9:8]==rx_data[2:1] -> latch the candidate mask, go to ADDR2 (no addr_done).
//   d) rx_data[7:3]==5'b11110 with rw=1, the remembered 10-bit slot valid and its addr[9:8]==rx_data[2:1] -> hit with the remembered idx, go to ACTIVE.
//   e) Otherwise -> addr_done with match_hit=0, go to IGNORE.
// - ADDR2 on byte_valid:
//   - A candidate with addr[7:0]==rx_data[7:0] -> hit (lowest index wins), remember idx with valid=1, go to ACTIVE.
//   - No such candidate -> miss, go to IGNORE.
// - Remembered 10-bit idx: cleared on stop and on any address outcome other than (d) or an ADDR2 hit.
// - match_hit, match_idx and gcall are updated in the same cycle as addr_done and then held.
// - ACTIVE/IGNORE ignore byte_valid.
// - bus_address, address_mode and addr_enable are sampled only at byte_valid; changes mid-transfer do not affect an already-resolved match.
// - bus_busy: set with start, cleared with stop.
// TESTING
// T1 7-bit: slot1=0x2A (mode 0, enabled); START, byte 0x55 -> addr_done; match_hit=1, match_idx=1, rw_mode=1.
// T2 Priority: slots 0 and 1 both 0x2A; byte 0x54 -> match_idx=0, rw_mode=0. With addr_enable=2'b00 -> match_hit=0, state IGNORE.
// T3 10-bit: slot0=10'h2F3 (mode 1); bytes 0xF4 -> no addr_done; 0xF3 -> hit idx 0. Then rSTART (rstart=1), byte 0xF5 -> hit idx 0, rw_mode=1. STOP -> match_hit=0, bus_busy=0.
// T4 General call: byte 0x00 -> gcall=1, match_hit=1. With GCALL_EN=0 -> match_hit=0, addr_done still pulses.
// T5 Glitch: SCL high, SDA low for FILTER_LEN-1 cycles -> no start. SDA low held -> start exactly FILTER_LEN+3 cycles after.
// T6 Corners: byte_valid coincident with stop -> no addr_done, FSM IDLE. n_rst asserted in ADDR2 -> all outputs 0, no start after release.

Source files
------------

// File: rtl/i2c_slave_addr_matcher.sv
// I2C slave front end: glitch-filtered SDA/SCL, START/rSTART/STOP pulses and
// address-phase decode against NUM_ADDR programmable 7/10-bit slots.

module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic line_i,
  output logic filt_o
);
  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic                  filt_q, filt_d;

  generate
    if (FILTER_LEN == 1) begin : g_one
      assign sr_d = sync_q[1];
    end else begin : g_many
      assign sr_d = {sr_q[FILTER_LEN-2:0], sync_q[1]};
    end
  endgenerate

  // Output only moves once every stage agrees; mixed history holds the old value.
  always_comb begin
    filt_d = filt_q;
    if (&sr_q)       filt_d = 1'b1;
    else if (~|sr_q) filt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '1;
      sr_q   <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      sr_q   <= sr_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
endmodule

module i2c_addr_slot (
  input  logic [9:0] addr_i,
  input  logic       mode_i,
  input  logic       en_i,
  input  logic [7:0] rx_i,
  input  logic       cand_i,
  output logic       hit7_o,
  output logic       hdr_o,
  output logic       hi_o,
  output logic       lo_o
);
  assign hit7_o = en_i & ~mode_i & (addr_i[6:0] == rx_i[7:1]);
  assign hi_o   = (addr_i[9:8] == rx_i[2:1]);
  assign hdr_o  = en_i & mode_i & hi_o;
  assign lo_o   = cand_i & (addr_i[7:0] == rx_i);
endmodule

module i2c_slave_addr_matcher #(
  parameter  int NUM_ADDR   = 2,
  parameter  int FILTER_LEN = 3,
  parameter  int GCALL_EN   = 1,
  localparam int IDX_W      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   SDA_sync,
  input  logic                   SCL_sync,
  input  logic [7:0]             rx_data,
  input  logic                   byte_valid,
  input  logic [10*NUM_ADDR-1:0] bus_address,
  input  logic [NUM_ADDR-1:0]    address_mode,
  input  logic [NUM_ADDR-1:0]    addr_enable,
  output logic                   start,
  output logic                   rstart,
  output logic                   stop,
  output logic                   bus_busy,
  output logic                   rw_mode,
  output logic                   addr_done,
  output logic                   match_hit,
  output logic [IDX_W-1:0]       match_idx,
  output logic                   gcall
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR1  = 3'd1;
  localparam logic [2:0] S_ADDR2  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_IGNORE = 3'd4;

  logic [1:0] line_in, line_f;
  logic       sda_f, scl_f, sda_prev_q, scl_prev_q;
  logic       start_det, stop_det;
  logic       start_q, rstart_q, stop_q, busy_q;

  assign line_in = {SCL_sync, SDA_sync};

  generate
    for (genvar l = 0; l < 2; l++) begin : g_filt
      i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk    (clk),
        .n_rst  (n_rst),
        .line_i (line_in[l]),
        .filt_o (line_f[l])
      );
    end
  endgenerate

  assign sda_f     = line_f[0];
  assign scl_f     = line_f[1];
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
      start_q    <= 1'b0;
      rstart_q   <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sda_prev_q <= sda_f;
      scl_prev_q <= scl_f;
      start_q    <= start_det;
      rstart_q   <= start_det & busy_q;
      stop_q     <= stop_det;
      if (start_det)     busy_q <= 1'b1;
      else if (stop_det) busy_q <= 1'b0;
    end
  end

  // Per-slot comparators
  logic [NUM_ADDR-1:0] hit7, hdr, hi, lo, cand_q, cand_d;

  generate
    for (genvar i = 0; i < NUM_ADDR; i++) begin : g_slot
      i2c_addr_slot u_slot (
        .addr_i (bus_address[10*i +: 10]),
        .mode_i (address_mode[i]),
        .en_i   (addr_enable[i]),
        .rx_i   (rx_data),
        .cand_i (cand_q[i]),
        .hit7_o (hit7[i]),
        .hdr_o  (hdr[i]),
        .hi_o   (hi[i]),
        .lo_o   (lo[i])
      );
    end
  endgenerate

  logic [IDX_W-1:0] idx7, idx_lo, rem_idx_q, rem_idx_d;
  logic             rem_vld_q, rem_vld_d, rem_hi;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    idx7   = '0;
    idx_lo = '0;
    rem_hi = 1'b0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      if (hit7[i]) idx7 = IDX_W'(i);
      if (lo[i])   idx_lo = IDX_W'(i);
      if (rem_idx_q == IDX_W'(i)) rem_hi = hi[i];
    end
  end

  logic [2:0]       state_q, state_d;
  logic             done_q, done_d, hit_q, hit_d, gcall_q, gcall_d, rw_q, rw_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_hdr;

  assign is_hdr = (rx_data[7:3] == 5'b11110);

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    idx_d     = idx_q;
    gcall_d   = gcall_q;
    rw_d      = rw_q;
    cand_d    = cand_q;
    rem_vld_d = rem_vld_q;
    rem_idx_d = rem_idx_q;
    if (stop_q) begin
      state_d   = S_IDLE;
      hit_d     = 1'b0;
      gcall_d   = 1'b0;
      rem_vld_d = 1'b0;
    end else if (start_q) begin
      state_d = S_ADDR1;
      hit_d   = 1'b0;
      gcall_d = 1'b0;
    end else if (byte_valid) begin
      case (state_q)
        S_ADDR1: begin
          rw_d   = rx_data[0];
          done_d = 1'b1;
          if ((GCALL_EN != 0) && (rx_data == 8'h00)) begin
            gcall_d   = 1'b1;
            hit_d     = 1'b1;
            idx_d     = '0;
            rem_vld_d = 1'b0;
            state_d   = S_ACTIVE;
          end else if (|hit7) begin
            hit_d     = 1'b1;
            idx_d     = idx7;
            rem_vld_d = 1'b0;
            state_d   = S_ACTIVE;
          end else if (is_hdr && !rx_data[0] && (|hdr)) begin
            // 10-bit write header: resolution waits for the low address byte
            done_d    = 1'b0;
            cand_d    = hdr;
            rem_vld_d = 1'b0;
            state_d   = S_ADDR2;
          end else if (is_hdr && rx_data[0] && rem_vld_q && rem_hi) begin
            hit_d   = 1'b1;
            idx_d   = rem_idx_q;
            state_d = S_ACTIVE;
          end else begin
            hit_d     = 1'b0;
            idx_d     = '0;
            rem_vld_d = 1'b0;
            state_d   = S_IGNORE;
          end
        end
        S_ADDR2: begin
          done_d = 1'b1;
          if (|lo) begin
            hit_d     = 1'b1;
            idx_d     = idx_lo;
            rem_vld_d = 1'b1;
            rem_idx_d = idx_lo;
            state_d   = S_ACTIVE;
          end else begin
            hit_d     = 1'b0;
            idx_d     = '0;
            rem_vld_d = 1'b0;
            state_d   = S_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      gcall_q   <= 1'b0;
      rw_q      <= 1'b0;
      cand_q    <= '0;
      rem_vld_q <= 1'b0;
      rem_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      gcall_q   <= gcall_d;
      rw_q      <= rw_d;
      cand_q    <= cand_d;
      rem_vld_q <= rem_vld_d;
      rem_idx_q <= rem_idx_d;
    end
  end

  assign start     = start_q;
  assign rstart    = rstart_q;
  assign stop      = stop_q;
  assign bus_busy  = busy_q;
  assign rw_mode   = rw_q;
  assign addr_done = done_q;
  assign match_hit = hit_q;
  assign match_idx = idx_q;
  assign gcall     = gcall_q;
endmodule

// File: tb/tb_i2c_slave_addr_matcher.sv
// Bench for i2c_slave_addr_matcher: directed scenarios plus randomized address
// phases checked against an address-decode reference model.

module tb_i2c_slave_addr_matcher;
  localparam int NA = 2;
  localparam int FL = 3;
  localparam int IW = 1;

  logic          clk = 1'b0, n_rst = 1'b0;
  logic          SDA_sync = 1'b1, SCL_sync = 1'b1, byte_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [10*NA-1:0] bus_address = '0;
  logic [NA-1:0] address_mode = '0, addr_enable = '0;

  logic start, rstart, stop, bus_busy, rw_mode, addr_done, match_hit, gcall;
  logic [IW-1:0] match_idx;
  logic start_n, rstart_n, stop_n, busy_n, rw_n, done_n, hit_n, gcall_n;
  logic [IW-1:0] idx_n;

  i2c_slave_addr_matcher #(.NUM_ADDR(NA), .FILTER_LEN(FL), .GCALL_EN(1)) dut (
    .clk(clk), .n_rst(n_rst), .SDA_sync(SDA_sync), .SCL_sync(SCL_sync),
    .rx_data(rx_data), .byte_valid(byte_valid), .bus_address(bus_address),
    .address_mode(address_mode), .addr_enable(addr_enable),
    .start(start), .rstart(rstart), .stop(stop), .bus_busy(bus_busy),
    .rw_mode(rw_mode), .addr_done(addr_done), .match_hit(match_hit),
    .match_idx(match_idx), .gcall(gcall));

  i2c_slave_addr_matcher #(.NUM_ADDR(NA), .FILTER_LEN(FL), .GCALL_EN(0)) dut_ng (
    .clk(clk), .n_rst(n_rst), .SDA_sync(SDA_sync), .SCL_sync(SCL_sync),
    .rx_data(rx_data), .byte_valid(byte_valid), .bus_address(bus_address),
    .address_mode(address_mode), .addr_enable(addr_enable),
    .start(start_n), .rstart(rstart_n), .stop(stop_n), .bus_busy(busy_n),
    .rw_mode(rw_n), .addr_done(done_n), .match_hit(hit_n),
    .match_idx(idx_n), .gcall(gcall_n));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         mph = 0;   // 0 no transfer, 1 expect first byte, 2 expect low byte, 3 resolved
  bit         m_busy = 0, m_rem_vld = 0, m_done = 0, m_hit = 0, m_gcall = 0, m_rw = 0;
  int         m_rem_idx = 0, m_idx = 0;
  bit [NA-1:0] m_cand = '0;
  logic [9:0] cfg_addr [NA];
  bit         cfg_mode [NA];
  bit         cfg_en   [NA];

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NA; i++) begin
      bus_address[10*i +: 10] = cfg_addr[i];
      address_mode[i] = cfg_mode[i];
      addr_enable[i]  = cfg_en[i];
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    int bi, s7, slo;
    bit [NA-1:0] cand;
    bi = int'(b);
    m_done = 0;
    if (mph == 1) begin
      m_rw = b[0]; m_done = 1; mph = 3; s7 = -1; cand = '0;
      for (int i = NA - 1; i >= 0; i--)
        if (cfg_en[i] && !cfg_mode[i] && (int'(cfg_addr[i]) % 128) == bi / 2) s7 = i;
      for (int i = 0; i < NA; i++)
        cand[i] = cfg_en[i] && cfg_mode[i] && (int'(cfg_addr[i]) / 256) == (bi / 2) % 4;
      if (bi == 0) begin
        m_gcall = 1; m_hit = 1; m_idx = 0; m_rem_vld = 0;
      end else if (s7 >= 0) begin
        m_hit = 1; m_idx = s7; m_rem_vld = 0;
      end else if (bi / 8 == 30 && bi % 2 == 0 && cand != 0) begin
        m_done = 0; mph = 2; m_cand = cand; m_rem_vld = 0;
      end else if (bi / 8 == 30 && bi % 2 == 1 && m_rem_vld &&
                   int'(cfg_addr[m_rem_idx]) / 256 == (bi / 2) % 4) begin
        m_hit = 1; m_idx = m_rem_idx;
      end else begin
        m_hit = 0; m_rem_vld = 0;
      end
    end else if (mph == 2) begin
      m_done = 1; mph = 3; slo = -1;
      for (int i = NA - 1; i >= 0; i--)
        if (m_cand[i] && int'(cfg_addr[i]) % 256 == bi) slo = i;
      if (slo >= 0) begin
        m_hit = 1; m_idx = slo; m_rem_vld = 1; m_rem_idx = slo;
      end else begin
        m_hit = 0; m_rem_vld = 0;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; byte_valid = 1'b1;
    tick(1);
    byte_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic bus_start();
    bit seen = 0;
    SCL_sync = 0; tick(FL + 6);
    SDA_sync = 1; tick(FL + 6);
    SCL_sync = 1; tick(FL + 6);
    SDA_sync = 0;
    for (int n = 0; n < 30 && !seen; n++) begin tick(1); if (start) seen = 1; end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL start_timeout: no start within 30 cycles"); end
    else begin
      n_tests++;
      if (rstart !== m_busy) begin n_fail++; $display("FAIL rstart: got %b expected %b", rstart, m_busy); end
      n_tests++;
      if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_start: got %b expected 1", bus_busy); end
    end
    m_busy = 1; mph = 1; m_hit = 0; m_gcall = 0;
    tick(1);
  endtask

  task automatic bus_stop();
    bit seen = 0;
    SCL_sync = 0; tick(FL + 6);
    SDA_sync = 0; tick(FL + 6);
    SCL_sync = 1; tick(FL + 6);
    SDA_sync = 1;
    for (int n = 0; n < 30 && !seen; n++) begin tick(1); if (stop) seen = 1; end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL stop_timeout: no stop within 30 cycles"); end
    else begin
      n_tests++;
      if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_stop: got %b expected 0", bus_busy); end
    end
    m_busy = 0; mph = 0; m_rem_vld = 0; m_hit = 0; m_gcall = 0;
    tick(1);
  endtask

  task automatic test_reset();
    bit ev = 0;
    tick(3);
    n_tests++;
    if ({start, rstart, stop, bus_busy, rw_mode, addr_done, match_hit, gcall, match_idx} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0",
        {start, rstart, stop, bus_busy, rw_mode, addr_done, match_hit, gcall, match_idx});
    end
    n_tests++;
    if ({start_n, rstart_n, stop_n, busy_n, rw_n, done_n, hit_n, gcall_n, idx_n} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs_ng: got %b expected 0",
        {start_n, rstart_n, stop_n, busy_n, rw_n, done_n, hit_n, gcall_n, idx_n});
    end
    n_rst = 1'b1;
    for (int n = 0; n < 20; n++) begin tick(1); if (start | stop) ev = 1; end
    n_tests++;
    if (ev !== 1'b0) begin n_fail++; $display("FAIL reset_release_event: got %b expected 0", ev); end
  endtask

  task automatic test_7bit();
    cfg_addr[0] = 10'h000; cfg_mode[0] = 0; cfg_en[0] = 0;
    cfg_addr[1] = 10'h02A; cfg_mode[1] = 0; cfg_en[1] = 1;
    apply_cfg();
    bus_start();
    send_byte(8'h55);
    n_tests++;
    if ({addr_done, match_hit, match_idx, rw_mode, gcall} !== 5'b11110) begin
      n_fail++; $display("FAIL t1_7bit: got done/hit/idx/rw/gc=%b expected 11110",
        {addr_done, match_hit, match_idx, rw_mode, gcall});
    end
    tick(1);
    n_tests++;
    if ({addr_done, match_hit} !== 2'b01) begin
      n_fail++; $display("FAIL t1_hold: got done/hit=%b expected 01", {addr_done, match_hit});
    end
    bus_stop();
  endtask

  task automatic test_priority();
    cfg_addr[0] = 10'h02A; cfg_mode[0] = 0; cfg_en[0] = 1;
    cfg_addr[1] = 10'h02A; cfg_mode[1] = 0; cfg_en[1] = 1;
    apply_cfg();
    bus_start();
    send_byte(8'h54);
    n_tests++;
    if ({addr_done, match_hit, match_idx, rw_mode} !== 4'b1100) begin
      n_fail++; $display("FAIL t2_lowest: got done/hit/idx/rw=%b expected 1100",
        {addr_done, match_hit, match_idx, rw_mode});
    end
    bus_start();
    cfg_en[0] = 0; cfg_en[1] = 0; apply_cfg();
    send_byte(8'h54);
    n_tests++;
    if ({addr_done, match_hit} !== 2'b10) begin
      n_fail++; $display("FAIL t2_disabled: got done/hit=%b expected 10", {addr_done, match_hit});
    end
    cfg_en[0] = 1; cfg_en[1] = 1; apply_cfg();
    tick(1);
    send_byte(8'h54);
    n_tests++;
    if ({addr_done, match_hit} !== 2'b00) begin
      n_fail++; $display("FAIL t2_ignore: got done/hit=%b expected 00", {addr_done, match_hit});
    end
    bus_stop();
  endtask

  task automatic test_10bit();
    cfg_addr[0] = 10'h2F3; cfg_mode[0] = 1; cfg_en[0] = 1;
    cfg_addr[1] = 10'h000; cfg_mode[1] = 0; cfg_en[1] = 0;
    apply_cfg();
    bus_start();
    send_byte(8'hF4);
    n_tests++;
    if ({addr_done, match_hit} !== 2'b00) begin
      n_fail++; $display("FAIL t3_hdr: got done/hit=%b expected 00", {addr_done, match_hit});
    end
    tick(1);
    send_byte(8'hF3);
    n_tests++;
    if ({addr_done, match_hit, match_idx} !== 3'b110) begin
      n_fail++; $display("FAIL t3_low: got done/hit/idx=%b expected 110", {addr_done, match_hit, match_idx});
    end
    bus_start();
    send_byte(8'hF5);
    n_tests++;
    if ({addr_done, match_hit, match_idx, rw_mode} !== 4'b1101) begin
      n_fail++; $display("FAIL t3_read: got done/hit/idx/rw=%b expected 1101",
        {addr_done, match_hit, match_idx, rw_mode});
    end
    bus_stop();
    tick(1);
    n_tests++;
    if ({match_hit, bus_busy} !== 2'b00) begin
      n_fail++; $display("FAIL t3_stop: got hit/busy=%b expected 00", {match_hit, bus_busy});
    end
  endtask

  task automatic test_gcall();
    cfg_addr[0] = 10'h02A; cfg_mode[0] = 0; cfg_en[0] = 1;
    cfg_addr[1] = 10'h031; cfg_mode[1] = 0; cfg_en[1] = 1;
    apply_cfg();
    bus_start();
    send_byte(8'h00);
    n_tests++;
    if ({addr_done, match_hit, gcall, match_idx} !== 4'b1110) begin
      n_fail++; $display("FAIL t4_gcall: got done/hit/gc/idx=%b expected 1110",
        {addr_done, match_hit, gcall, match_idx});
    end
    n_tests++;
    if ({done_n, hit_n, gcall_n} !== 3'b100) begin
      n_fail++; $display("FAIL t4_gcall_off: got done/hit/gc=%b expected 100", {done_n, hit_n, gcall_n});
    end
    bus_stop();
  endtask

  task automatic test_glitch();
    bit ev = 0;
    int first = -1;
    SDA_sync = 0; tick(FL - 1);
    SDA_sync = 1;
    for (int n = 0; n < 20; n++) begin tick(1); if (start | stop) ev = 1; end
    n_tests++;
    if (ev !== 1'b0) begin n_fail++; $display("FAIL t5_glitch: got event=%b expected 0", ev); end
    SDA_sync = 0;
    for (int n = 1; n <= FL + 10; n++) begin
      tick(1);
      if (start && first < 0) first = n;
      if (n == FL + 5) begin
        n_tests++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL t5_width: got start=%b expected 0", start); end
      end
    end
    n_tests++;
    if (first != FL + 4) begin n_fail++; $display("FAIL t5_latency: got %0d expected %0d", first, FL + 4); end
    m_busy = 1; mph = 1; m_hit = 0; m_gcall = 0;
    bus_stop();
  endtask

  task automatic test_corners();
    bit ev = 0;
    cfg_addr[0] = 10'h02A; cfg_mode[0] = 0; cfg_en[0] = 1;
    cfg_addr[1] = 10'h02A; cfg_mode[1] = 0; cfg_en[1] = 1;
    apply_cfg();
    bus_start();
    SCL_sync = 0; tick(FL + 6);
    SDA_sync = 0; tick(FL + 6);
    SCL_sync = 1; tick(FL + 6);
    SDA_sync = 1; tick(FL + 4);
    n_tests++;
    if (stop !== 1'b1) begin n_fail++; $display("FAIL t6_stop_time: got %b expected 1", stop); end
    rx_data = 8'h54; byte_valid = 1'b1;
    tick(1);
    byte_valid = 1'b0;
    m_busy = 0; mph = 0; m_rem_vld = 0; m_hit = 0; m_gcall = 0;
    n_tests++;
    if ({addr_done, match_hit} !== 2'b00) begin
      n_fail++; $display("FAIL t6_bv_stop: got done/hit=%b expected 00", {addr_done, match_hit});
    end
    tick(2);
    send_byte(8'h54);
    n_tests++;
    if (addr_done !== 1'b0) begin n_fail++; $display("FAIL t6_idle: got done=%b expected 0", addr_done); end
    cfg_addr[0] = 10'h2F3; cfg_mode[0] = 1; apply_cfg();
    bus_start();
    send_byte(8'hF4);
    n_rst = 1'b0; SDA_sync = 1'b1;
    tick(2);
    n_tests++;
    if ({start, rstart, stop, bus_busy, rw_mode, addr_done, match_hit, gcall, match_idx} !== 9'b0) begin
      n_fail++; $display("FAIL t6_reset: got %b expected 0",
        {start, rstart, stop, bus_busy, rw_mode, addr_done, match_hit, gcall, match_idx});
    end
    n_rst = 1'b1;
    m_busy = 0; mph = 0; m_rem_vld = 0; m_hit = 0; m_gcall = 0; m_rw = 0;
    for (int n = 0; n < 25; n++) begin tick(1); if (start | stop) ev = 1; end
    n_tests++;
    if (ev !== 1'b0) begin n_fail++; $display("FAIL t6_post_reset: got event=%b expected 0", ev); end
    send_byte(8'hF3);
    n_tests++;
    if (addr_done !== 1'b0) begin n_fail++; $display("FAIL t6_reset_idle: got done=%b expected 0", addr_done); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int j, sel;
    for (int it = 0; it < 40; it++) begin
      if (it % 4 == 0) begin
        for (int i = 0; i < NA; i++) begin
          cfg_addr[i] = 10'($urandom);
          cfg_mode[i] = 1'($urandom);
          cfg_en[i]   = ($urandom % 4) != 0;
        end
        apply_cfg();
      end
      bus_start();
      j = int'($urandom % NA);
      sel = int'($urandom % 5);
      case (sel)
        0: b = 8'h00;
        1: b = {cfg_addr[j][6:0], 1'($urandom)};
        2: b = {5'b11110, cfg_addr[j][9:8], 1'b0};
        3: b = {5'b11110, cfg_addr[j][9:8], 1'b1};
        default: b = 8'($urandom);
      endcase
      send_byte(b);
      n_tests++;
      if ({addr_done, match_hit, gcall, rw_mode} !== {m_done, m_hit, m_gcall, m_rw}) begin
        n_fail++; $display("FAIL rnd_byte1 %02h: got done/hit/gc/rw=%b expected %b",
          b, {addr_done, match_hit, gcall, rw_mode}, {m_done, m_hit, m_gcall, m_rw});
      end
      if (m_hit) begin
        n_tests++;
        if (match_idx !== IW'(m_idx)) begin
          n_fail++; $display("FAIL rnd_idx1 %02h: got %0d expected %0d", b, match_idx, m_idx);
        end
      end
      if (mph == 2) begin
        tick(1);
        b = ($urandom % 2 == 0) ? cfg_addr[int'($urandom % NA)][7:0] : 8'($urandom);
        send_byte(b);
        n_tests++;
        if ({addr_done, match_hit, gcall} !== {m_done, m_hit, m_gcall}) begin
          n_fail++; $display("FAIL rnd_byte2 %02h: got done/hit/gc=%b expected %b",
            b, {addr_done, match_hit, gcall}, {m_done, m_hit, m_gcall});
        end
        if (m_hit) begin
          n_tests++;
          if (match_idx !== IW'(m_idx)) begin
            n_fail++; $display("FAIL rnd_idx2 %02h: got %0d expected %0d", b, match_idx, m_idx);
          end
        end
      end
      tick(2);
      n_tests++;
      if ({addr_done, match_hit} !== {1'b0, m_hit}) begin
        n_fail++; $display("FAIL rnd_hold: got done/hit=%b expected %b", {addr_done, match_hit}, {1'b0, m_hit});
      end
      if ($urandom % 2 == 0) bus_stop();
    end
    if (m_busy) bus_stop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_7bit();
    test_priority();
    test_10bit();
    test_gcall();
    test_glitch();
    test_corners();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
